commu_rx_inf: RTL and testbench
===============================

# commu_rx_inf

Serial receiver for the commu link. It is the far-end consumer of the frames produced by the commu transmit interface. It recovers 16-bit words from the single-wire `rx` line using the same framing: one low start bit, 16 data bits MSB first, then high stop bits, each bit lasting `tbit_period` clk_sys cycles. Each word is presented on `data_rx` with a one-cycle `done_rx` strobe. Malformed frames raise `err_rx` instead.

## Interface
- Parameters: none.
- `clk_sys`  input  1  system clock.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rx`  input  1  serial line, idle high, asynchronous to clk_sys.
- `tbit_period`  input  20  bit length in clk_sys cycles; legal range 4..2^20-1.
- `data_rx`  output  16  last correctly received word; holds between frames.
- `done_rx`  output  1  one-cycle pulse; `data_rx` valid from the same cycle.
- `err_rx`  output  1  one-cycle pulse on start-glitch-free frame with bad stop bit.

## Operation
- `rx` passes through a 2-FF synchronizer (`rx_s`), reset value 1. `rx_d` is `rx_s` delayed by one cycle, reset value 1. `fall = rx_d & ~rx_s`.
- `tbit_lat[19:0]` captures `tbit_period` when `fall` is seen in IDLE. All timing in the frame uses `tbit_lat`, so changes to `tbit_period` mid-frame have no effect. `H = tbit_lat >> 1` (floor).
- Cycle counter `cnt[19:0]` clears on every state change and otherwise increments while not IDLE. Bit counter `nbit[3:0]`.
- FSM states:
  - IDLE → START when `fall`, with cnt=0.
  - START: at cnt==H-1, if `rx_s`==0 → DATA (nbit=0); else → IDLE as a glitch, with no error.
  - DATA: at cnt==tbit_lat-1, shift `rx_s` into `sh[15:0]` as `sh <= {sh[14:0], rx_s}`. If nbit==15 → STOP; else nbit+1.
  - STOP: at cnt==tbit_lat-1, if `rx_s`==1 then `data_rx <= sh` and `done_rx <= 1`; else `err_rx <= 1` and `data_rx` is unchanged. In both cases → IDLE.
  - Undefined encodings → IDLE.
- Only the first stop bit is checked. The second transmitted stop bit plus the transmitter's done cycle give guard time in which IDLE rearms.
- Rearm requires a fresh high→low transition. A line held low after an error (break) produces no further frames or errors.
- Sampling occurs at bit centres: the start sample is at H, and each later sample is one full `tbit_lat` later.

## Timing
- Reset values: `data_rx`=16'h0000, `done_rx`=0, `err_rx`=0, FSM=IDLE, cnt=0, nbit=0, sh=0, tbit_lat=0.
- `done_rx` and `err_rx` are registered outputs, high for exactly one cycle.
- Let edge E0 be the clk_sys edge at which the first synchronizer stage captures `rx`=0.
  - START is entered at E0+2.
  - The start sample is at E0+2+H.
  - Data bit k (k=15..0) is sampled at E0+2+H+(16-k)·T.
  - `done_rx`/`err_rx` go high after edge E0+2+H+17·T, where T=`tbit_lat`.
- Earliest next frame acceptance: the cycle after `done_rx`, provided `rx_s` has returned high.
- Asserting `rst_n` mid-frame aborts immediately. There is no strobe, `data_rx` returns to 0, and the next frame needs a new falling edge after release.

## Test plan
- Nominal: T=8, send 0xA5C3 with 2 stop bits → `data_rx`=0xA5C3, a single `done_rx` pulse 142 edges after E0, `err_rx` stays 0.
- Loopback with the transmit interface at T=4: back-to-back words 0x0000, 0xFFFF, 0x8001, 0x7FFE → four `done_rx` pulses with matching `data_rx` in order, no `err_rx`.
- Glitch: T=16, `rx` low for 3 cycles then high → no `done_rx`/`err_rx`, FSM back in IDLE. A following valid 0x1234 frame is received correctly.
- Framing error: after receiving 0x00FF, send 0x5555 with stop bit 0 → one `err_rx` pulse, `data_rx` remains 0x00FF. Holding `rx` low for 100 more bits → no further strobes.
- `tbit_period` changed from 8 to 20 mid-frame → the frame is still decoded at T=8. The next frame, sent at T=20, decodes correctly.
- Reset mid-frame: `rst_n` low during bit 7 of 0xBEEF, then a clean 0x0F0F frame → outputs held at reset values during reset, only 0x0F0F reported.

Source files
------------

// File: rtl/commu_rx_inf.sv
// rtl/commu_rx_inf.sv - commu link serial receiver: start/16 data MSB-first/stop framing to 16-bit words
module commu_rx_inf (
    input  logic        clk_sys,
    input  logic        rst_n,
    input  logic        rx,
    input  logic [19:0] tbit_period,
    output logic [15:0] data_rx,
    output logic        done_rx,
    output logic        err_rx
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_START = 2'd1,
        S_DATA  = 2'd2,
        S_STOP  = 2'd3
    } state_t;

    state_t      state_q, state_d;
    logic        sync1_q, sync1_d;
    logic        rx_s_q, rx_s_d;
    logic        rx_d_q, rx_d_d;
    logic [19:0] tbit_lat_q, tbit_lat_d;
    logic [19:0] cnt_q, cnt_d;
    logic [3:0]  nbit_q, nbit_d;
    logic [15:0] sh_q, sh_d;
    logic [15:0] data_rx_q, data_rx_d;
    logic        done_q, done_d;
    logic        err_q, err_d;

    logic        fall;
    logic [19:0] half_m1;
    logic [19:0] full_m1;

    assign fall    = rx_d_q & ~rx_s_q;
    assign half_m1 = (tbit_lat_q >> 1) - 20'd1;
    assign full_m1 = tbit_lat_q - 20'd1;

    always_comb begin
        sync1_d    = rx;
        rx_s_d     = sync1_q;
        rx_d_d     = rx_s_q;
        state_d    = state_q;
        tbit_lat_d = tbit_lat_q;
        cnt_d      = (state_q == S_IDLE) ? 20'd0 : cnt_q + 20'd1;
        nbit_d     = nbit_q;
        sh_d       = sh_q;
        data_rx_d  = data_rx_q;
        done_d     = 1'b0;
        err_d      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (fall) begin
                    tbit_lat_d = tbit_period;
                    state_d    = S_START;
                    cnt_d      = 20'd0;
                end
            end
            S_START: begin
                // A start bit that is high again at its centre is treated as noise.
                if (cnt_q == half_m1) begin
                    cnt_d   = 20'd0;
                    nbit_d  = 4'd0;
                    state_d = rx_s_q ? S_IDLE : S_DATA;
                end
            end
            S_DATA: begin
                if (cnt_q == full_m1) begin
                    cnt_d = 20'd0;
                    sh_d  = {sh_q[14:0], rx_s_q};
                    if (nbit_q == 4'd15) begin
                        state_d = S_STOP;
                    end else begin
                        nbit_d = nbit_q + 4'd1;
                    end
                end
            end
            S_STOP: begin
                if (cnt_q == full_m1) begin
                    cnt_d   = 20'd0;
                    state_d = S_IDLE;
                    if (rx_s_q) begin
                        data_rx_d = sh_q;
                        done_d    = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 20'd0;
            end
        endcase
    end

    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q    <= 1'b1;
            rx_s_q     <= 1'b1;
            rx_d_q     <= 1'b1;
            state_q    <= S_IDLE;
            tbit_lat_q <= 20'd0;
            cnt_q      <= 20'd0;
            nbit_q     <= 4'd0;
            sh_q       <= 16'h0000;
            data_rx_q  <= 16'h0000;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            sync1_q    <= sync1_d;
            rx_s_q     <= rx_s_d;
            rx_d_q     <= rx_d_d;
            state_q    <= state_d;
            tbit_lat_q <= tbit_lat_d;
            cnt_q      <= cnt_d;
            nbit_q     <= nbit_d;
            sh_q       <= sh_d;
            data_rx_q  <= data_rx_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign data_rx = data_rx_q;
    assign done_rx = done_q;
    assign err_rx  = err_q;

endmodule

// File: tb/tb_commu_rx_inf.sv
// tb/tb_commu_rx_inf.sv - self-checking bench for commu_rx_inf against a frame-level expectation queue
module tb_commu_rx_inf;

    logic        clk_sys;
    logic        rst_n;
    logic        rx;
    logic [19:0] tbit_period;
    logic [15:0] data_rx;
    logic        done_rx;
    logic        err_rx;

    commu_rx_inf dut (
        .clk_sys     (clk_sys),
        .rst_n       (rst_n),
        .rx          (rx),
        .tbit_period (tbit_period),
        .data_rx     (data_rx),
        .done_rx     (done_rx),
        .err_rx      (err_rx)
    );

    initial clk_sys = 1'b0;
    always #5 clk_sys = ~clk_sys;

    typedef struct {
        bit          is_err;
        logic [15:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [15:0] model_last;
    int          n_checks;
    int          n_errors;
    int          cyc;
    int          last_e0;
    int          last_strobe_cyc;
    int          n_strobes;
    int          chg_bit;
    logic [19:0] chg_val;
    int          rst_bit;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    always @(posedge clk_sys) cyc++;

    // Every strobe must match the oldest outstanding frame outcome.
    always @(posedge clk_sys) begin
        #1;
        if (done_rx || err_rx) begin
            n_strobes++;
            last_strobe_cyc = cyc;
            chk("both_strobes", {31'd0, done_rx & err_rx}, 32'd0);
            if (exp_q.size() == 0) begin
                chk("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("strobe_kind", {31'd0, err_rx}, {31'd0, e.is_err});
                if (!e.is_err) model_last = e.word;
                chk("data_rx", {16'd0, data_rx}, {16'd0, model_last});
            end
        end
    end

    task automatic send_frame(input logic [15:0] w, input int t, input int nstop,
                              input bit stop_ok, input bit expect_it);
        exp_t e;
        if (expect_it) begin
            e.is_err = !stop_ok;
            e.word   = w;
            exp_q.push_back(e);
        end
        @(negedge clk_sys);
        rx      = 1'b0;
        last_e0 = cyc + 1;
        repeat (t) @(negedge clk_sys);
        for (int k = 15; k >= 0; k--) begin
            rx = w[k];
            if (k == chg_bit) tbit_period = chg_val;
            if (k == rst_bit) begin
                repeat (t / 2) @(negedge clk_sys);
                rst_n = 1'b0;
                exp_q.delete();
                model_last = 16'h0000;
                repeat (3) @(negedge clk_sys);
                chk("rst_data", {16'd0, data_rx}, 32'd0);
                chk("rst_done", {31'd0, done_rx}, 32'd0);
                chk("rst_err", {31'd0, err_rx}, 32'd0);
                rx    = 1'b1;
                rst_n = 1'b1;
                return;
            end
            repeat (t) @(negedge clk_sys);
        end
        rx = stop_ok;
        repeat (t) @(negedge clk_sys);
        if (nstop > 1) begin
            rx = 1'b1;
            repeat ((nstop - 1) * t) @(negedge clk_sys);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 64 && exp_q.size() > 0; i++) @(negedge clk_sys);
        chk("drain", exp_q.size(), 32'd0);
    endtask

    initial begin
        int t;
        int s0;
        logic [15:0] w;
        logic [15:0] lb[4];
        n_checks   = 0;
        n_errors   = 0;
        cyc        = 0;
        n_strobes  = 0;
        model_last = 16'h0000;
        chg_bit    = -1;
        chg_val    = 20'd0;
        rst_bit    = -1;
        rst_n      = 1'b0;
        rx         = 1'b1;
        tbit_period = 20'd8;
        repeat (4) @(negedge clk_sys);
        chk("reset_data", {16'd0, data_rx}, 32'd0);
        chk("reset_done", {31'd0, done_rx}, 32'd0);
        chk("reset_err", {31'd0, err_rx}, 32'd0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk_sys);

        // Nominal frame and strobe latency.
        send_frame(16'hA5C3, 8, 2, 1'b1, 1'b1);
        drain();
        chk("nominal_latency", last_strobe_cyc - last_e0, 32'd142);
        chk("nominal_hold", {16'd0, data_rx}, 32'h0000A5C3);

        // Back-to-back words at the minimum bit period.
        tbit_period = 20'd4;
        lb[0] = 16'h0000; lb[1] = 16'hFFFF; lb[2] = 16'h8001; lb[3] = 16'h7FFE;
        for (int i = 0; i < 4; i++) begin
            send_frame(lb[i], 4, 2, 1'b1, 1'b1);
            @(negedge clk_sys);
        end
        drain();
        chk("loopback_last", {16'd0, data_rx}, 32'h00007FFE);

        // Short low glitch must be ignored silently.
        tbit_period = 20'd16;
        s0 = n_strobes;
        @(negedge clk_sys);
        rx = 1'b0;
        repeat (3) @(negedge clk_sys);
        rx = 1'b1;
        repeat (40) @(negedge clk_sys);
        chk("glitch_quiet", n_strobes - s0, 32'd0);
        send_frame(16'h1234, 16, 2, 1'b1, 1'b1);
        drain();

        // Framing error followed by a line break.
        tbit_period = 20'd8;
        send_frame(16'h00FF, 8, 2, 1'b1, 1'b1);
        drain();
        send_frame(16'h5555, 8, 1, 1'b0, 1'b1);
        drain();
        s0 = n_strobes;
        repeat (100 * 8) @(negedge clk_sys);
        chk("break_quiet", n_strobes - s0, 32'd0);
        chk("err_hold", {16'd0, data_rx}, 32'h000000FF);
        rx = 1'b1;
        repeat (16) @(negedge clk_sys);

        // Bit period change mid-frame does not affect the frame in flight.
        chg_bit = 10;
        chg_val = 20'd20;
        send_frame(16'h3C96, 8, 2, 1'b1, 1'b1);
        chg_bit = -1;
        drain();
        send_frame(16'h6A59, 20, 2, 1'b1, 1'b1);
        drain();

        // Reset during a frame aborts it.
        tbit_period = 20'd8;
        rst_bit = 7;
        send_frame(16'hBEEF, 8, 2, 1'b1, 1'b1);
        rst_bit = -1;
        repeat (20) @(negedge clk_sys);
        chk("post_rst_data", {16'd0, data_rx}, 32'd0);
        send_frame(16'h0F0F, 8, 2, 1'b1, 1'b1);
        drain();
        chk("post_rst_frame", {16'd0, data_rx}, 32'h00000F0F);

        // Randomised frames, periods and stop-bit faults.
        for (int i = 0; i < 24; i++) begin
            t = $urandom_range(4, 10);
            w = 16'($urandom);
            tbit_period = 20'(t);
            if ($urandom_range(0, 4) == 0) begin
                send_frame(w, t, 1, 1'b0, 1'b1);
                rx = 1'b1;
                repeat (2 * t) @(negedge clk_sys);
            end else begin
                send_frame(w, t, 2, 1'b1, 1'b1);
                repeat ($urandom_range(1, t)) @(negedge clk_sys);
            end
            drain();
            chk("rand_hold", {16'd0, data_rx}, {16'd0, model_last});
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #5000000;
        $display("FAIL timeout: simulation time limit reached");
        $fatal(1);
    end

endmodule
